// File: rtl/lce_pkg.sv
// Constants and FSM encoding shared by the local-contrast pipeline stages
// (control FSM, padding, window fetch, histogram).
package lce_pkg;
   localparam int IMG_W = 150;
   localparam int IMG_H = 150;
   localparam int WIN   = 15;
   localparam int PAD   = (WIN - 1) / 2;
   localparam int PW    = IMG_W + 2 * PAD;
   localparam int DW    = 8;
   localparam int AW    = 15;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
endpackage

// File: rtl/win_addr_gen.sv
// Window address generator: raster cursor, window base and the incremental
// in-window read address (no multiplier).
module win_addr_gen #(
   parameter int IMG_W = 150,
   parameter int IMG_H = 150,
   parameter int WIN   = 15,
   parameter int AW    = 15
) (
   input  logic          clk,
   input  logic          re,
   input  logic          load,
   input  logic          step,
   input  logic          advance,
   output logic [AW-1:0] addr,
   output logic          last_rd,
   output logic          is_centre,
   output logic          frame_last
);
   localparam int PAD = (WIN - 1) / 2;
   localparam int PW  = IMG_W + 2 * PAD;
   localparam int RW  = $clog2(WIN);
   localparam int XW  = $clog2(IMG_W);
   localparam int YW  = $clog2(IMG_H);

   localparam logic [RW-1:0] RMAX     = RW'(WIN - 1);
   localparam logic [RW-1:0] RCEN     = RW'(PAD);
   localparam logic [XW-1:0] XMAX     = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YMAX     = YW'(IMG_H - 1);
   localparam logic [AW-1:0] ROW_SKIP = AW'(PW - WIN + 1);
   localparam logic [AW-1:0] LINE_ADV = AW'(WIN);

   logic [AW-1:0] base;
   logic [RW-1:0] r, c;
   logic [XW-1:0] col;
   logic [YW-1:0] row;

   assign last_rd    = (r == RMAX) && (c == RMAX);
   assign is_centre  = (r == RCEN) && (c == RCEN);
   assign frame_last = (row == YMAX) && (col == XMAX);

   always_ff @(posedge clk) begin
      if (re) begin
         base <= '0;
         addr <= '0;
         r    <= '0;
         c    <= '0;
         row  <= '0;
         col  <= '0;
      end else begin
         if (load) begin
            addr <= base;
            r    <= '0;
            c    <= '0;
         end else if (step) begin
            if (c == RMAX) begin
               c    <= '0;
               r    <= (r == RMAX) ? '0 : r + 1'b1;
               addr <= addr + ROW_SKIP;
            end else begin
               c    <= c + 1'b1;
               addr <= addr + 1'b1;
            end
         end
         // End of an image row jumps the base over both padding bands (PW-IMG_W+1 == WIN).
         if (advance) begin
            if (col != XMAX) begin
               col  <= col + 1'b1;
               base <= base + 1'b1;
            end else if (row != YMAX) begin
               col  <= '0;
               row  <= row + 1'b1;
               base <= base + LINE_ADV;
            end else begin
               col  <= '0;
               row  <= '0;
               base <= '0;
            end
         end
      end
   end
endmodule

// File: rtl/window_fetch.sv
// Streams the WINxWIN neighbourhood of the current centre pixel from the
// padded-image RAM, one pixel per cycle, and latches the centre pixel.
module window_fetch #(
   parameter int IMG_W = lce_pkg::IMG_W,
   parameter int IMG_H = lce_pkg::IMG_H,
   parameter int WIN   = lce_pkg::WIN,
   parameter int DW    = lce_pkg::DW,
   parameter int AW    = lce_pkg::AW
) (
   input  logic          clk,
   input  logic          re,
   input  logic          start,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_dout,
   output logic          win_valid,
   output logic [DW-1:0] win_pix,
   output logic          win_last,
   output logic [DW-1:0] cen_pix,
   output logic          wf,
   output logic          frame_end
);
   import lce_pkg::*;

   state_t state, state_nx;
   logic   last_rd, is_centre, frame_last, cen_q;

   win_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .AW(AW)) u_addr (
      .clk       (clk),
      .re        (re),
      .load      ((state == IDLE) && start),
      .step      (state == FETCH),
      .advance   (state == DONE),
      .addr      (mem_addr),
      .last_rd   (last_rd),
      .is_centre (is_centre),
      .frame_last(frame_last)
   );

   always_ff @(posedge clk) begin
      if (re) state <= IDLE;
      else    state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: if (last_rd) state_nx = DRAIN;
         DRAIN: state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign mem_rd_en = (state == FETCH);
   assign wf        = (state == DONE);
   assign frame_end = wf && frame_last;
   // RAM has one cycle of latency, so the data for each read lines up with the delayed strobe.
   assign win_pix   = win_valid ? mem_dout : '0;

   always_ff @(posedge clk) begin
      if (re) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         cen_q     <= 1'b0;
         cen_pix   <= '0;
      end else begin
         win_valid <= mem_rd_en;
         win_last  <= mem_rd_en && last_rd;
         cen_q     <= mem_rd_en && is_centre;
         if (win_valid && cen_q) cen_pix <= mem_dout;
      end
   end
endmodule
